vote_pattern_gen: RTL

//  Inverse of the one-hot vote tally. Takes a one-hot vote count and enumerates,
//  one per handshake, every N-bit ballot vector whose popcount equals that count.

---
 rtl/vote_pattern_gen_if.sv | 26 ++
 rtl/vote_pattern_gen.sv | 134 +++++++++++++
 2 files changed

// File: rtl/vote_pattern_gen_if.sv
// Command and pattern channels of the ballot pattern generator.
// master drives commands / consumes patterns; slave is the generator.
interface vote_pattern_gen_if #(
  parameter int N = 3
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [N:0]   cmd_count;
  logic         pat_valid;
  logic         pat_ready;
  logic [N-1:0] pat_data;
  logic         pat_last;
  logic [7:0]   pat_idx;

  modport master (
    output cmd_valid, cmd_count, pat_ready,
    input  cmd_ready, pat_valid, pat_data,
    input  pat_last, pat_idx
  );

  modport slave (
    input  cmd_valid, cmd_count, pat_ready,
    output cmd_ready, pat_valid, pat_data,
    output pat_last, pat_idx
  );
endinterface

// File: rtl/vote_pattern_gen.sv
// Enumerates every N-bit ballot with popcount k, ascending, one per handshake.
// Ports: clk, rst_n, bus (cmd/pat channels), err (bad command pulse), busy.
module vote_pattern_gen #(
  parameter int N = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  vote_pattern_gen_if.slave   bus,
  output logic                err,
  output logic                busy
);
  localparam int KW = $clog2(N + 1);
  localparam logic [N-1:0] ONES = '1;
  localparam logic [N:0]   C1 = 1;
  localparam logic [N-1:0] INC = 1;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    HOLD
  } st_t;

  st_t st, st_nx;

  logic [KW-1:0] k;
  logic [KW-1:0] kin;
  logic [N-1:0]  cand;
  logic [N-1:0]  pdata;
  logic [N-1:0]  lastmask;
  logic          plast;
  logic [7:0]    pidx;
  logic          onehot;
  logic          acc;
  logic          hit;
  logic          hs;

  function automatic logic [KW-1:0] popcnt(
    input logic [N-1:0] v
  );
    logic [KW-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) begin
      s = s + KW'(v[i]);
    end
    return s;
  endfunction

  always_comb begin
    kin = '0;
    for (int i = 0; i <= N; i++) begin
      if (bus.cmd_count[i]) kin = KW'(i);
    end
  end

  assign onehot = (|bus.cmd_count) &&
    ((bus.cmd_count & (bus.cmd_count - C1)) == '0);
  assign acc = bus.cmd_valid & (st == IDLE);
  assign hit = (popcnt(cand) == k);
  // Largest ballot with k ones: the top k bits set.
  assign lastmask = ~(ONES >> k);
  assign hs = bus.pat_valid & bus.pat_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE: if (acc && onehot) st_nx = SCAN;
      SCAN: if (hit) st_nx = HOLD;
      HOLD: if (hs) st_nx = plast ? IDLE : SCAN;
      default: st_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready = 1'b0;
    bus.pat_valid = 1'b0;
    busy          = 1'b0;
    unique case (1'b1)
      (st == IDLE): bus.cmd_ready = 1'b1;
      (st == SCAN): busy = 1'b1;
      (st == HOLD): begin
        busy          = 1'b1;
        bus.pat_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.pat_data = pdata;
  assign bus.pat_last = plast;
  assign bus.pat_idx  = pidx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k     <= '0;
      cand  <= '0;
      pdata <= '0;
      plast <= 1'b0;
      pidx  <= '0;
      err   <= 1'b0;
    end else begin
      err <= acc & ~onehot;
      unique case (st)
        IDLE: begin
          if (acc && onehot) begin
            k    <= kin;
            cand <= '0;
            pidx <= '0;
          end
        end
        SCAN: begin
          if (hit) begin
            pdata <= cand;
            plast <= (cand == lastmask);
          end else begin
            cand <= cand + INC;
          end
        end
        HOLD: begin
          // lastmask ends the run, so cand never wraps
          if (hs && !plast) begin
            cand <= cand + INC;
            pidx <= pidx + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
